// File: rtl/layer_collect_pkg.sv
// Shared types and constants for the layer argmax collector.
package layer_collect_pkg;

    localparam int unsigned ELEM_W = 16;

    typedef enum logic [0:0] {
        S_COLLECT,
        S_REPORT
    } collect_state_t;

    typedef logic signed [ELEM_W-1:0] elem_t;

    localparam elem_t ELEM_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

endpackage

// File: rtl/collect_buffer.sv
// M x T element store: one write port and an independent registered read port.
module collect_buffer #(
    parameter int unsigned M    = 8,
    parameter int unsigned T    = 16,
    parameter int unsigned LOGM = 3
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [LOGM-1:0] wr_addr,
    input  logic [T-1:0]    wr_data,
    input  logic [LOGM-1:0] rd_addr,
    output logic [T-1:0]    rd_data
);

    // Contents survive reset; only the most recent writes matter.
    logic [T-1:0] mem [M];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/layer_argmax_collector.sv
// Collects one M-element signed vector, tracks its argmax and reports it on a valid/ready port.
// Optional idle-abort of partial vectors is enabled with COLLECTOR_TIMEOUT_EN.
module layer_argmax_collector
    import layer_collect_pkg::*;
#(
    parameter int unsigned M       = 8,
    parameter int unsigned T       = 16,
    parameter int unsigned LOGM    = 3,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [T-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LOGM-1:0]     out_index,
    output logic signed [T-1:0] out_value,
    input  logic [LOGM-1:0]     rd_addr,
    output logic [T-1:0]        rd_data,
    output logic                err
);

    if (M > (1 << LOGM) || M < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("layer_argmax_collector: illegal M/LOGM/TIMEOUT combination");
    end

    collect_state_t      state_q, state_d;
    logic [LOGM-1:0]     count_q, count_d;
    logic signed [T-1:0] best_val_q, best_val_d;
    logic [LOGM-1:0]     best_idx_q, best_idx_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [LOGM-1:0]     out_index_q, out_index_d;
    logic signed [T-1:0] out_value_q, out_value_d;
    logic                beat;
    logic                take;
    logic signed [T-1:0] cand_val;
    logic [LOGM-1:0]     cand_idx;

`ifdef COLLECTOR_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT) + 1;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              err_q, err_d;
`endif

    assign beat = in_valid && in_ready_q;

    collect_buffer #(.M(M), .T(T), .LOGM(LOGM)) u_buffer (
        .clk     (clk),
        .wr_en   (beat),
        .wr_addr (count_q),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_COLLECT;
            count_q     <= '0;
            best_val_q  <= T'(ELEM_MIN);
            best_idx_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_value_q <= '0;
`ifdef COLLECTOR_TIMEOUT_EN
            idle_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_value_q <= out_value_d;
`ifdef COLLECTOR_TIMEOUT_EN
            idle_q      <= idle_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next-state, running argmax and registered handshake outputs
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_value_d = out_value_q;
`ifdef COLLECTOR_TIMEOUT_EN
        idle_d      = idle_q;
        err_d       = 1'b0;
`endif
        // First element loads unconditionally; strict compare keeps the lower index on ties.
        take     = (count_q == '0) || (in_data > best_val_q);
        cand_val = take ? in_data : best_val_q;
        cand_idx = take ? count_q : best_idx_q;

        case (state_q)
            S_COLLECT: begin
                in_ready_d = 1'b1;
                if (beat) begin
                    best_val_d = cand_val;
                    best_idx_d = cand_idx;
                    count_d    = count_q + LOGM'(1);
`ifdef COLLECTOR_TIMEOUT_EN
                    idle_d     = '0;
`endif
                    if (count_q == LOGM'(M - 1)) begin
                        state_d     = S_REPORT;
                        count_d     = '0;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        out_index_d = cand_idx;
                        out_value_d = cand_val;
                    end
                end
`ifdef COLLECTOR_TIMEOUT_EN
                else if (count_q != '0) begin
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        count_d = '0;
                        idle_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
`endif
            end
            S_REPORT: begin
                in_ready_d = 1'b0;
                if (out_valid_q && out_ready) begin
                    state_d     = S_COLLECT;
                    count_d     = '0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_value = out_value_q;

`ifdef COLLECTOR_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
